// File: rtl/nmr_bstrm_pkg.sv
// ----------------------------------------------------------------------------
// nmr_bstrm_pkg : shared types and mode decode for the NMR bitstream generator
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nmr_bstrm_pkg;

  localparam int DEF_DATA_WIDTH = 120;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int PAT_MAX_LEN    = DEF_DATA_WIDTH - DEF_LEN_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT   = 2'd0,
    ONES  = 2'd1,
    ZEROS = 2'd2,
    HOLD  = 2'd3
  } mode_t;

  // Pattern wins over all_1s, which wins over all_0s; no flag means a delay.
  function automatic mode_t decode_mode(input logic pat, input logic ones,
                                        input logic zeros);
    if (pat)   return PAT;
    if (ones)  return ONES;
    if (zeros) return ZEROS;
    return HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nmr_bstrm_bitclk.sv
// ----------------------------------------------------------------------------
// nmr_bstrm_bitclk : CLK_PER_BIT prescaler producing a bit-advance strobe
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nmr_bstrm_bitclk #(
  parameter int CLK_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tick
);

  generate
    if (CLK_PER_BIT <= 1) begin : g_div1
      logic unused_div1;
      assign unused_div1 = ^{clk, rst_n, restart};
      assign tick        = run;
    end else begin : g_divn
      localparam int PW = $clog2(CLK_PER_BIT);
      localparam logic [PW-1:0] LAST = PW'(CLK_PER_BIT - 1);

      logic [PW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (restart) begin
          cnt <= '0;
        end else if (run) begin
          cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
      end

      assign tick = run && (cnt == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/nmr_bstrm_gen.sv
// ----------------------------------------------------------------------------
// nmr_bstrm_gen : serialises one decoded command onto the NMR control line
// Optional macro NMR_BSTRM_GEN_DIFF_EN adds the complementary output BSTRM_OUT_N
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nmr_bstrm_gen
  import nmr_bstrm_pkg::*;
#(
  parameter int   DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int   CNT_WIDTH   = 32,
  parameter int   LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int   CLK_PER_BIT = 1,
  parameter logic IDLE_LVL    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BST_START,
  output logic                  BST_DONE,
  input  logic [DATA_WIDTH-1:0] in_data_reg,
  input  logic                  in_seq_end_reg,
  input  logic                  in_pattern_mode_reg,
  input  logic                  in_all_1s_mode_reg,
  input  logic                  in_all_0s_mode_reg,
  output logic                  BSTRM_OUT,
  output logic                  BUSY,
  output logic                  SEQ_DONE
`ifdef NMR_BSTRM_GEN_DIFF_EN
  ,
  output logic                  BSTRM_OUT_N
`endif
);

  localparam int PAT_MAX = DATA_WIDTH - LEN_WIDTH;
  localparam int BW      = (CNT_WIDTH > LEN_WIDTH) ? CNT_WIDTH : LEN_WIDTH;
  localparam logic [BW-1:0] PAT_MAX_BW = BW'(PAT_MAX);

  state_t               state;
  mode_t                mode;
  logic                 seq_end;
  logic [PAT_MAX-1:0]   shreg;
  logic [BW-1:0]        remaining;

  logic                 accept;
  logic                 tick;
  mode_t                mode_in;
  logic [BW-1:0]        len_in;
  logic [BW-1:0]        count_in;
  logic                 first_bit;
  logic                 next_bit;
  logic                 out_next;

  assign accept  = (state == IDLE) && BST_START;
  assign mode_in = decode_mode(in_pattern_mode_reg, in_all_1s_mode_reg,
                               in_all_0s_mode_reg);

  always_comb begin
    len_in = BW'(in_data_reg[DATA_WIDTH-1 -: LEN_WIDTH]);
    if (len_in > PAT_MAX_BW) len_in = PAT_MAX_BW;
    count_in = (mode_in == PAT) ? len_in : BW'(in_data_reg[CNT_WIDTH-1:0]);

    case (mode_in)
      PAT:     first_bit = in_data_reg[0];
      ONES:    first_bit = 1'b1;
      ZEROS:   first_bit = 1'b0;
      default: first_bit = BSTRM_OUT;
    endcase

    case (mode)
      PAT:     next_bit = shreg[0];
      ONES:    next_bit = 1'b1;
      ZEROS:   next_bit = 1'b0;
      default: next_bit = BSTRM_OUT;
    endcase
  end

  // Level the serial line takes at the coming edge; shared by both polarities
  // so the differential pair never skews.
  always_comb begin
    out_next = BSTRM_OUT;
    case (state)
      IDLE: begin
        if (BST_START) begin
          if (count_in == '0) out_next = in_seq_end_reg ? IDLE_LVL : BSTRM_OUT;
          else                out_next = first_bit;
        end
      end
      RUN: begin
        if (tick) begin
          if (remaining == BW'(1)) out_next = seq_end ? IDLE_LVL : BSTRM_OUT;
          else                     out_next = next_bit;
        end
      end
      default: out_next = BSTRM_OUT;
    endcase
  end

  nmr_bstrm_bitclk #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_bitclk (
    .clk     (CLK),
    .rst_n   (RST),
    .restart (accept),
    .run     (state == RUN),
    .tick    (tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      mode      <= HOLD;
      seq_end   <= 1'b0;
      shreg     <= '0;
      remaining <= '0;
      BSTRM_OUT <= IDLE_LVL;
      BUSY      <= 1'b0;
      BST_DONE  <= 1'b0;
      SEQ_DONE  <= 1'b0;
    end else begin
      BSTRM_OUT <= out_next;
      BST_DONE  <= 1'b0;
      SEQ_DONE  <= 1'b0;
      case (state)
        IDLE: begin
          if (BST_START) begin
            mode      <= mode_in;
            seq_end   <= in_seq_end_reg;
            shreg     <= in_data_reg[PAT_MAX-1:0] >> 1;
            remaining <= count_in;
            BUSY      <= 1'b1;
            if (count_in == '0) begin
              state    <= DONE;
              BST_DONE <= 1'b1;
              SEQ_DONE <= in_seq_end_reg;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (remaining == BW'(1)) begin
              state     <= DONE;
              remaining <= '0;
              BST_DONE  <= 1'b1;
              SEQ_DONE  <= seq_end;
            end else begin
              remaining <= remaining - BW'(1);
              shreg     <= shreg >> 1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NMR_BSTRM_GEN_DIFF_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) BSTRM_OUT_N <= ~IDLE_LVL;
    else      BSTRM_OUT_N <= ~out_next;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nmr_bstrm_gen.sv
// ----------------------------------------------------------------------------
// tb_nmr_bstrm_gen : scoreboard bench, one DUT at CLK_PER_BIT=1 and one at 3
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nmr_bstrm_gen;

  typedef struct {
    int           nbits;
    logic [127:0] bits;
    logic         od;
    logic         sd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bst_start = 1'b0;
  logic [119:0] in_data = '0;
  logic         seq_end = 1'b0, pat = 1'b0, ones = 1'b0, zeros = 1'b0;
  logic [1:0]   done_o, out_o, busy_o, seqd_o;
`ifdef NMR_BSTRM_GEN_DIFF_EN
  logic [1:0]   outn_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int issued  = 0;
  int pops [2];
  bit cap_on [2];
  int start_cyc [2];
  int ncap [2];
  logic [511:0] cap [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  nmr_bstrm_gen #(.CLK_PER_BIT(1)) u_dut0 (
    .CLK(clk), .RST(rst_n), .BST_START(bst_start), .BST_DONE(done_o[0]),
    .in_data_reg(in_data), .in_seq_end_reg(seq_end),
    .in_pattern_mode_reg(pat), .in_all_1s_mode_reg(ones),
    .in_all_0s_mode_reg(zeros), .BSTRM_OUT(out_o[0]), .BUSY(busy_o[0]),
    .SEQ_DONE(seqd_o[0])
`ifdef NMR_BSTRM_GEN_DIFF_EN
    , .BSTRM_OUT_N(outn_o[0])
`endif
  );

  nmr_bstrm_gen #(.CLK_PER_BIT(3)) u_dut1 (
    .CLK(clk), .RST(rst_n), .BST_START(bst_start), .BST_DONE(done_o[1]),
    .in_data_reg(in_data), .in_seq_end_reg(seq_end),
    .in_pattern_mode_reg(pat), .in_all_1s_mode_reg(ones),
    .in_all_0s_mode_reg(zeros), .BSTRM_OUT(out_o[1]), .BUSY(busy_o[1]),
    .SEQ_DONE(seqd_o[1])
`ifdef NMR_BSTRM_GEN_DIFF_EN
    , .BSTRM_OUT_N(outn_o[1])
`endif
  );

  function automatic int cpb_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor step for one instance: capture the stream, score on BST_DONE.
  task automatic mon_step(input int i);
    exp_t e;
    int   lat;
    bit   bad;
    bit   empty;
    if (seqd_o[i] && !done_o[i]) check($sformatf("seq_done_alone%0d", i), 1, 0);
    if (cap_on[i]) begin
      if (done_o[i]) begin
        cap_on[i] = 1'b0;
        pops[i]++;
        empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          check($sformatf("unexpected_done%0d", i), 1, 0);
        end else begin
          e   = (i == 0) ? q0.pop_front() : q1.pop_front();
          lat = cyc - start_cyc[i];
          check($sformatf("latency%0d", i), lat, 1 + e.nbits * cpb_of(i));
          bad = 1'b0;
          for (int k = 0; k < ncap[i]; k++)
            if (cap[i][k] !== e.bits[(k / cpb_of(i)) % 128]) bad = 1'b1;
          check($sformatf("stream%0d", i), bad, 0);
          check($sformatf("out_at_done%0d", i), out_o[i], e.od);
          check($sformatf("seq_done%0d", i), seqd_o[i], e.sd);
        end
      end else if (ncap[i] < 512) begin
        cap[i][ncap[i]] = out_o[i];
        ncap[i]++;
      end
    end else if (done_o[i]) begin
      pops[i]++;
      check($sformatf("stray_done%0d", i), 1, 0);
    end
    if (!cap_on[i] && bst_start && !busy_o[i]) begin
      cap_on[i]    = 1'b1;
      start_cyc[i] = cyc;
      ncap[i]      = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pops[i] = 0; cap_on[i] = 1'b0; start_cyc[i] = 0; ncap[i] = 0; cap[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
`ifdef NMR_BSTRM_GEN_DIFF_EN
      check("diff0", outn_o[0], ~out_o[0]);
      check("diff1", outn_o[1], ~out_o[1]);
`endif
      if (!rst_n) begin
        cap_on[0] = 1'b0;
        cap_on[1] = 1'b0;
      end else begin
        mon_step(0);
        mon_step(1);
      end
    end
  end

  task automatic send(input logic [119:0] d, input logic [3:0] fl, input int nb,
                      input logic [127:0] bits, input logic od, input logic sd,
                      input bit poke);
    exp_t e;
    int   t;
    e.nbits = nb; e.bits = bits; e.od = od; e.sd = sd;
    q0.push_back(e);
    q1.push_back(e);
    issued++;
    @(posedge clk); #1;
    in_data = d;
    {seq_end, pat, ones, zeros} = fl;
    bst_start = 1'b1;
    @(posedge clk); #1;
    bst_start = 1'b0;
    in_data = ~d;
    {seq_end, pat, ones, zeros} = ~fl;
    if (poke) begin
      @(posedge clk); #1;
      bst_start = 1'b1;
      in_data   = '1;
      @(posedge clk); #1;
      bst_start = 1'b0;
    end
    t = 0;
    while (t < 3000 && (pops[0] < issued || pops[1] < issued)) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", (t < 3000), 1);
  endtask

  initial begin
    logic [119:0] d;
    logic [127:0] b;

    // Reset state, sampled while reset is held and just after release.
    repeat (2) @(negedge clk);
    check("rst_out", out_o, 2'b00);
    check("rst_busy", busy_o, 2'b00);
    check("rst_done", done_o, 2'b00);
    check("rst_seqd", seqd_o, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy_o, 2'b00);

    // all_1s, N=10: ten ones, output stays 1 afterwards.
    d = '0; d[31:0] = 32'd10;
    send(d, 4'b0010, 10, 128'h3FF, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("ones_hold_after", out_o, 2'b11);

    // Pattern L=8, data 1011_0010 -> 0,1,0,0,1,1,0,1.
    d = '0; d[119:112] = 8'd8; d[7:0] = 8'b1011_0010;
    send(d, 4'b0100, 8, 128'hB2, 1'b1, 1'b0, 1'b0);

    // all_0s N=2, then hold N=3 keeps 0, then hold N=0 finishes immediately.
    d = '0; d[31:0] = 32'd2;
    send(d, 4'b0001, 2, 128'h0, 1'b0, 1'b0, 1'b0);
    d = '0; d[31:0] = 32'd3;
    send(d, 4'b0000, 3, 128'h0, 1'b0, 1'b0, 1'b0);
    d = '0;
    send(d, 4'b0000, 0, 128'h0, 1'b0, 1'b0, 1'b0);
    check("hold0_out", out_o, 2'b00);

    // Pattern and all_1s both set: pattern L=4 data 0101 -> 1,0,1,0; poke ignored.
    d = '0; d[119:112] = 8'd4; d[3:0] = 4'b0101; d[31:8] = 24'hFFFFFF;
    send(d, 4'b0110, 4, 128'h5, 1'b0, 1'b0, 1'b1);

    // seq_end with all_1s N=4: four ones then idle level in the DONE cycle.
    d = '0; d[31:0] = 32'd4;
    send(d, 4'b1010, 4, 128'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("seq_end_idle", out_o, 2'b00);

    // Over-long pattern length is clamped to 112 bits.
    d = '0; d[119:112] = 8'd200;
    for (int k = 0; k < 112; k++) d[k] = (k % 2 == 1);
    b = '0;
    for (int k = 0; k < 112; k++) b[k] = (k % 2 == 1);
    send(d, 4'b0100, 112, b, 1'b1, 1'b0, 1'b0);

    // Reset mid-run of all_1s N=50: immediate idle, no BST_DONE.
    @(posedge clk); #1;
    d = '0; d[31:0] = 32'd50;
    in_data = d; {seq_end, pat, ones, zeros} = 4'b0010; bst_start = 1'b1;
    @(posedge clk); #1;
    bst_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", busy_o, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out", out_o, 2'b00);
    check("abort_busy", busy_o, 2'b00);
    check("abort_done", done_o, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);

    check("done_count0", pops[0], issued);
    check("done_count1", pops[1], issued);
    check("queue0_empty", q0.size(), 0);
    check("queue1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
